// File: rtl/w_full.sv
// Write-domain pointer, fill level and full/almost-full flags for the dual-clock FIFO.
// Optional sticky overflow detection is compiled in with `define W_FULL_OVERFLOW_EN.
module w_full #(
  parameter int ADDR_W    = 7,
  parameter int AF_THRESH = 120
) (
  input  logic              w_clk,
  input  logic              n_rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_count_sync,
  input  logic              overflow_clr,
  output logic              w_accept,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W-1:0] w_count,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W:0] w_binary_q, w_binary_d;
  logic [ADDR_W:0] wptr_q, w_gray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic [ADDR_W:0] r_bin_s;
  logic            full_q, full_d;
  logic            af_q, af_d;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state pointer, level and flags; increment gated by the registered full.
  always_comb begin
    w_accept   = w_en & ~full_q;
    w_binary_d = w_binary_q + {{ADDR_W{1'b0}}, w_accept};
    w_gray_d   = (w_binary_d >> 1) ^ w_binary_d;
    r_bin_s    = gray2bin(r_count_sync);
    level_d    = w_binary_d - r_bin_s;
    full_d     = (w_gray_d == {~r_count_sync[ADDR_W:ADDR_W-1], r_count_sync[ADDR_W-2:0]});
    af_d       = (level_d >= AF_LVL);
  end

  // Pointer, level and flag registers.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      w_binary_q <= {(ADDR_W+1){1'b0}};
      wptr_q     <= {(ADDR_W+1){1'b0}};
      level_q    <= {(ADDR_W+1){1'b0}};
      full_q     <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      w_binary_q <= w_binary_d;
      wptr_q     <= w_gray_d;
      level_q    <= level_d;
      full_q     <= full_d;
      af_q       <= af_d;
    end
  end

`ifdef W_FULL_OVERFLOW_EN
  logic overflow_q;

  // Sticky write-while-full error; a new violation beats a same-cycle clear.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q <= 1'b0;
    end else if (w_en & full_q) begin
      overflow_q <= 1'b1;
    end else if (overflow_clr) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_overflow_clr;
  assign unused_overflow_clr = overflow_clr;
  assign overflow            = 1'b0;
`endif

  assign wptr        = wptr_q;
  assign w_count     = w_binary_q[ADDR_W-1:0];
  assign full        = full_q;
  assign almost_full = af_q;
  assign w_level     = level_q;

endmodule

// File: tb/tb_w_full.sv
// Self-checking bench for w_full: reference tracks total writes and reads as plain integers.
module tb_w_full;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int AF    = 120;
`ifdef W_FULL_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        w_clk = 1'b0;
  logic        n_rst;
  logic        w_en;
  logic [7:0]  r_count_sync;
  logic        overflow_clr;
  logic        w_accept;
  logic [7:0]  wptr;
  logic [6:0]  w_count;
  logic        full;
  logic        almost_full;
  logic [7:0]  w_level;
  logic        overflow;

  always #5 w_clk = ~w_clk;

  w_full #(.ADDR_W(AW), .AF_THRESH(AF)) dut (
    .w_clk(w_clk), .n_rst(n_rst), .w_en(w_en), .r_count_sync(r_count_sync),
    .overflow_clr(overflow_clr), .w_accept(w_accept), .wptr(wptr),
    .w_count(w_count), .full(full), .almost_full(almost_full),
    .w_level(w_level), .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;
  int wr    = 0;   // total accepted writes
  int rd    = 0;   // total reads visible to the write side
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  function automatic logic [7:0] gray(input int v);
    logic [7:0] b;
    b = v[7:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int lvl(input int w, input int r);
    return (w - r) % 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_wptr"},  {24'd0, wptr}, {24'd0, gray(wr)});
    check({tag, "_wcount"}, {25'd0, w_count}, wr % DEPTH);
    check({tag, "_full"},  {31'd0, full}, {31'd0, m_full});
    check({tag, "_af"},    {31'd0, almost_full}, (lvl(wr, rd) >= AF) ? 32'd1 : 32'd0);
    check({tag, "_level"}, {24'd0, w_level}, lvl(wr, rd));
    check({tag, "_ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // One clock: drive, check combinational accept, advance reference at the edge, check.
  task automatic cycle(input bit en, input bit clr, input string tag);
    bit acc;
    w_en         = en;
    overflow_clr = clr;
    r_count_sync = gray(rd);
    #1;
    acc = en && !m_full;
    check({tag, "_accept"}, {31'd0, w_accept}, {31'd0, acc});
    @(posedge w_clk);
    if (OVF_ON && en && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (acc) wr++;
    m_full = (lvl(wr, rd) == DEPTH);
    #1;
    check_all(tag);
  endtask

  task automatic random_reads();
    if (wr > rd && $urandom_range(0, 3) == 0) rd += $urandom_range(1, wr - rd);
  endtask

  initial begin
    int q[$];
    int cyc;
    n_rst = 1'b0; w_en = 1'b0; overflow_clr = 1'b0; r_count_sync = 8'h00;
    #12 n_rst = 1'b1;
    check_all("reset");
    @(posedge w_clk); #1;

    // Warm-up with random writes and reads.
    for (int i = 0; i < 40; i++) begin
      random_reads();
      cycle($urandom_range(0, 3) != 0, 1'b0, "warm");
    end

    // Drain completely, then fill from empty with reads frozen at zero.
    rd = wr;
    cycle(1'b0, 1'b0, "drain0");
    n_rst = 1'b0; #1; n_rst = 1'b1;
    wr = 0; rd = 0; m_full = 1'b0; m_ovf = 1'b0;
    #1 check_all("rst_fill");
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, "fill");
      if (i == AF - 1) check("fill_af_before", {31'd0, almost_full}, 32'd0);
      if (i == AF)     check("fill_af_at",     {31'd0, almost_full}, 32'd1);
      if (i == DEPTH - 1) check("fill_full_before", {31'd0, full}, 32'd0);
    end
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_level", {24'd0, w_level}, 32'd128);
    check("fill_wptr_c0", {24'd0, wptr}, 32'h0000_00C0);
    check("fill_wcount", {25'd0, w_count}, 32'd0);

    // Write while full; overflow sticky, set beats clear, then clear.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "wfull");
    check("wfull_wptr_hold", {24'd0, wptr}, 32'h0000_00C0);
    cycle(1'b0, 1'b0, "ovf_hold");
    cycle(1'b1, 1'b1, "ovf_setclr");
    check("ovf_set_wins", {31'd0, overflow}, {31'd0, OVF_ON});
    cycle(1'b0, 1'b1, "ovf_clr");

    // Read advance and write together at full: no write this edge, full drops.
    rd = 1;
    cycle(1'b1, 1'b0, "drain1");
    check("drain1_full", {31'd0, full}, 32'd0);
    check("drain1_level", {24'd0, w_level}, 32'd127);
    check("drain1_wptr", {24'd0, wptr}, 32'h0000_00C0);

    // Mid-stream reset, then wrap with reads following wptr two cycles late.
    cycle(1'b0, 1'b0, "pre_rst");
    n_rst = 1'b0;
    #1;
    wr = 0; rd = 0; m_full = 1'b0; m_ovf = 1'b0;
    check_all("midrst");
    #2 n_rst = 1'b1;
    q = {0, 0};
    cyc = 0;
    while (wr < 256 && cyc < 2000) begin
      rd = q[0];
      cycle($urandom_range(0, 3) != 0, 1'b0, "wrap");
      check("wrap_nofull", {31'd0, full}, 32'd0);
      check("wrap_level_le3", {31'd0, (w_level <= 8'd3)}, 32'd1);
      void'(q.pop_front());
      q.push_back(wr);
      cyc++;
    end
    check("wrap_budget", wr, 32'd256);
    check("wrap_wptr_00", {24'd0, wptr}, 32'd0);

    // Random soak with write-heavy traffic to revisit full/almost-full.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) random_reads();
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, "soak");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
